// File: rtl/sfq_pulse_window_counter.sv
// Decodes a toggle-encoded SFQ pulse stream into per-window pulse counts.
// Flags too-close pulses and buffers completed counts in a show-ahead FIFO.
module sfq_pulse_window_counter #(
    parameter int CNT_W      = 8,
    parameter int WINDOW     = 16,
    parameter int MIN_GAP    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overflow,
    output logic             drop,
    output logic             viol,
    output logic [1:0]       state_dbg
);

    localparam int WC_W  = $clog2(WINDOW);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_IDLE  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             q_prev;
    logic [WC_W-1:0]  wcnt;
    logic [WC_W-1:0]  wcnt_nxt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic [CNT_W-1:0] acc_sum;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;
    logic             pulse;
    logic             push;
    logic             ovf_set;
    logic             viol_set;

    // PRIME has no valid previous sample, so it can never report a pulse.
    always_comb begin
        pulse   = (state != ST_PRIME) && (q_in != q_prev);
        acc_sum = (pulse && (acc != CNT_MAX)) ? acc + 1'b1 : acc;
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        acc_nxt   = acc;
        push      = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            ST_PRIME: begin
                state_nxt = en ? ST_COUNT : ST_IDLE;
                wcnt_nxt  = '0;
                acc_nxt   = '0;
            end
            ST_IDLE: begin
                wcnt_nxt = '0;
                acc_nxt  = '0;
                if (en) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    // Abandon the partial window; nothing is pushed.
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = '0;
                    acc_nxt   = '0;
                end else begin
                    ovf_set = pulse && (acc == CNT_MAX);
                    if (wcnt == WC_LAST) begin
                        push     = 1'b1;
                        wcnt_nxt = '0;
                        acc_nxt  = '0;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                        acc_nxt  = acc_sum;
                    end
                end
            end
            default: begin
                state_nxt = ST_PRIME;
                wcnt_nxt  = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        viol_set = pulse && (gap < GAP_MAX);
        if (pulse) begin
            gap_nxt = GAP_W'(1);
        end else if (gap < GAP_MAX) begin
            gap_nxt = gap + 1'b1;
        end else begin
            gap_nxt = gap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_PRIME;
            q_prev <= 1'b0;
            wcnt   <= '0;
            acc    <= '0;
            gap    <= GAP_MAX;
        end else begin
            state  <= state_nxt;
            q_prev <= q_in;
            wcnt   <= wcnt_nxt;
            acc    <= acc_nxt;
            gap    <= gap_nxt;
        end
    end

    // Read port: cnt_valid means the head is a real count; the entry leaves
    // on any clock where cnt_valid && cnt_ready, and cnt_data reads 0 when empty.
    logic [CNT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;
    logic             drop_set;

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop        = !fifo_empty && cnt_ready;
        // A simultaneous pop frees the slot the push needs, even when full.
        wr_en      = push && (!fifo_full || pop);
        drop_set   = push && fifo_full && !pop;
        cnt_valid  = !fifo_empty;
        cnt_data   = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= acc_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop     <= 1'b0;
            viol     <= 1'b0;
        end else begin
            overflow <= overflow | ovf_set;
            drop     <= drop | drop_set;
            viol     <= viol | viol_set;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sfq_pulse_window_counter.sv
// Directed bench for sfq_pulse_window_counter: stimulus pushes expected window
// counts into exp_q; a negedge monitor pops and compares on every FIFO read.
module tb_sfq_pulse_window_counter;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             q_in = 1'b0;
    logic             en = 1'b0;
    logic             cnt_ready = 1'b0;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_valid;
    logic             overflow;
    logic             drop;
    logic             viol;
    logic [1:0]       state_dbg;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] mon_exp;

    sfq_pulse_window_counter #(
        .CNT_W(CNT_W),
        .WINDOW(16),
        .MIN_GAP(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q_in(q_in),
        .en(en),
        .cnt_data(cnt_data),
        .cnt_valid(cnt_valid),
        .cnt_ready(cnt_ready),
        .overflow(overflow),
        .drop(drop),
        .viol(viol),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    // monitor: compare every accepted FIFO head against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cnt_valid && cnt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got %0d required none", cnt_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("entry", int'(cnt_data), int'(mon_exp));
                end
            end
        end
    end

    // driver tasks: inputs change at posedge+2, so each cyc() is one DUT clock
    task automatic cyc(input logic tog);
        if (tog) q_in = ~q_in;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic qi, input logic e, input logic r);
        rst       = 1'b1;
        q_in      = qi;
        en        = e;
        cnt_ready = r;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cnt_valid", cnt_valid, 0);
        check("rst_cnt_data", cnt_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop, 0);
        check("rst_viol", viol, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
    endtask

    task automatic run_window(input logic [15:0] mask, input logic [CNT_W-1:0] exp_v,
                              input bit do_push, input bit chk_lat);
        for (int i = 0; i < 16; i++) begin
            if (chk_lat && i == 15) check("valid_before_last", cnt_valid, 0);
            cyc(mask[i]);
        end
        if (do_push) exp_q.push_back(exp_v);
        if (chk_lat) check("valid_after_last", cnt_valid, 1);
    endtask

    task automatic drain(input int n);
        en        = 1'b0;
        cnt_ready = 1'b1;
        repeat (n) cyc(1'b0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    logic [15:0] win_mask [5];

    initial begin
        win_mask[0] = 16'h0001;
        win_mask[1] = 16'h0009;
        win_mask[2] = 16'h0049;
        win_mask[3] = 16'h0249;
        win_mask[4] = 16'h1249;

        // q_in high through reset release: PRIME must hide the 0->1 step
        do_reset(1'b1, 1'b1, 1'b1);
        cyc(1'b0);
        run_window(16'h0000, 3'd0, 1'b1, 1'b1);
        check("t1_viol", viol, 0);
        drain(4);

        // five pulses three clocks apart
        do_reset(1'b0, 1'b1, 1'b1);
        cyc(1'b0);
        run_window(16'h1249, 3'd5, 1'b1, 1'b1);
        check("t2_viol", viol, 0);
        check("t2_overflow", overflow, 0);
        drain(4);

        // back-to-back pulses: violation, both still counted
        do_reset(1'b0, 1'b1, 1'b1);
        cyc(1'b0);
        run_window(16'h0030, 3'd2, 1'b1, 1'b0);
        check("t3_viol", viol, 1);
        drain(4);
        check("t3_viol_sticky", viol, 1);

        // consumer stalled: fifth window dropped
        do_reset(1'b0, 1'b1, 1'b0);
        cyc(1'b0);
        for (int k = 0; k < 4; k++) run_window(win_mask[k], 3'(k + 1), 1'b1, 1'b0);
        check("t4_drop_before", drop, 0);
        check("t4_valid_full", cnt_valid, 1);
        run_window(win_mask[4], 3'd5, 1'b0, 1'b0);
        check("t4_drop_after", drop, 1);
        drain(8);

        // fifth push lands on a pop cycle: accepted, no drop
        do_reset(1'b0, 1'b1, 1'b0);
        cyc(1'b0);
        for (int k = 0; k < 4; k++) run_window(win_mask[k], 3'(k + 1), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) cnt_ready = 1'b1;
            cyc(win_mask[4][i]);
        end
        exp_q.push_back(3'd5);
        check("t4b_drop", drop, 0);
        drain(8);

        // eight pulses into a 3-bit count: saturate at 7
        do_reset(1'b0, 1'b1, 1'b1);
        cyc(1'b0);
        run_window(16'h5555, 3'd7, 1'b1, 1'b0);
        check("t5_overflow", overflow, 1);
        check("t5_viol", viol, 0);
        drain(4);

        // abort at wcnt=8, pulse while idle, then a clean window
        do_reset(1'b0, 1'b1, 1'b1);
        cyc(1'b0);
        for (int i = 0; i < 8; i++) cyc(i % 3 == 0);
        en = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        check("t6_state_idle", state_dbg, 1);
        check("t6_no_entry", cnt_valid, 0);
        en = 1'b1;
        cyc(1'b0);
        run_window(16'h0022, 3'd2, 1'b1, 1'b1);
        drain(6);

        // reset mid-window with a held entry and a sticky flag
        cnt_ready = 1'b0;
        en        = 1'b1;
        cyc(1'b0);
        run_window(16'h000C, 3'd2, 1'b0, 1'b0);
        check("t6b_viol", viol, 1);
        check("t6b_valid", cnt_valid, 1);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("t6b_rst_valid", cnt_valid, 0);
        check("t6b_rst_data", cnt_data, 0);
        check("t6b_rst_viol", viol, 0);
        check("t6b_rst_overflow", overflow, 0);
        check("t6b_rst_drop", drop, 0);
        check("t6b_rst_state", state_dbg, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
